// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline: forwarding selects,
// ALU control codes and the ID/EX register layout.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_ANDN = 3'b100;
   localparam logic [2:0] ALU_ORN  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memwrite;
      logic              memtoreg;
      logic              alusrc;
      logic              regdst;
      logic [2:0]        alucontrol;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] signimm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding select for one EX source index: the youngest in-flight producer
// (MEM before WB) wins; register 0 never forwards.
module fwd_unit
   import mips_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [RW-1:0] i_src_e,
   input  logic [RW-1:0] i_writereg_m,
   input  logic          i_regwrite_m,
   input  logic [RW-1:0] i_writereg_w,
   input  logic          i_regwrite_w,
   output fwd_sel_t      o_sel
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = i_regwrite_m && (i_writereg_m != {RW{1'b0}}) && (i_writereg_m == i_src_e);
   assign w_hit_w = i_regwrite_w && (i_writereg_w != {RW{1'b0}}) && (i_writereg_w == i_src_e);

   // Priority select between MEM, WB and the captured register-file value
   always_comb begin
      o_sel = FWD_REG;
      if (w_hit_m) begin
         o_sel = FWD_MEM;
      end else if (w_hit_w) begin
         o_sel = FWD_WB;
      end else begin
         o_sel = FWD_REG;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and the
// load-use stall request.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int RW = REG_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          stall_e,
   input  logic          flush_e,
   input  logic          valid_d,
   input  logic [DW-1:0] rd1_d,
   input  logic [DW-1:0] rd2_d,
   input  logic [DW-1:0] signimm_d,
   input  logic [RW-1:0] rs_d,
   input  logic [RW-1:0] rt_d,
   input  logic [RW-1:0] rd_d,
   input  logic [2:0]    alucontrol_d,
   input  logic          alusrc_d,
   input  logic          regdst_d,
   input  logic          regwrite_d,
   input  logic          memwrite_d,
   input  logic          memtoreg_d,
   input  logic [DW-1:0] aluout_m,
   input  logic [RW-1:0] writereg_m,
   input  logic          regwrite_m,
   input  logic [DW-1:0] result_w,
   input  logic [RW-1:0] writereg_w,
   input  logic          regwrite_w,
   output logic [DW-1:0] srca_e,
   output logic [DW-1:0] srcb_e,
   output logic [2:0]    alucont_e,
   output logic [DW-1:0] writedata_e,
   output logic [RW-1:0] writereg_e,
   output logic          regwrite_e,
   output logic          memwrite_e,
   output logic          memtoreg_e,
   output logic          valid_e,
   output logic [1:0]    forwarda_e,
   output logic [1:0]    forwardb_e,
   output logic          lwstall
);

   id_ex_t   r_idex;
   fwd_sel_t w_fwda;
   fwd_sel_t w_fwdb;

   // Pipeline register: flush outranks stall, stall outranks capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idex <= '0;
      end else if (flush_e) begin
         r_idex <= '0;
      end else if (stall_e) begin
         r_idex <= r_idex;
      end else begin
         r_idex.valid      <= valid_d;
         r_idex.regwrite   <= regwrite_d;
         r_idex.memwrite   <= memwrite_d;
         r_idex.memtoreg   <= memtoreg_d;
         r_idex.alusrc     <= alusrc_d;
         r_idex.regdst     <= regdst_d;
         r_idex.alucontrol <= alucontrol_d;
         r_idex.rd1        <= rd1_d;
         r_idex.rd2        <= rd2_d;
         r_idex.signimm    <= signimm_d;
         r_idex.rs         <= rs_d;
         r_idex.rt         <= rt_d;
         r_idex.rd         <= rd_d;
      end
   end

   fwd_unit #(.RW(RW)) u_fwd_rs (
      .i_src_e      (r_idex.rs),
      .i_writereg_m (writereg_m),
      .i_regwrite_m (regwrite_m),
      .i_writereg_w (writereg_w),
      .i_regwrite_w (regwrite_w),
      .o_sel        (w_fwda)
   );

   fwd_unit #(.RW(RW)) u_fwd_rt (
      .i_src_e      (r_idex.rt),
      .i_writereg_m (writereg_m),
      .i_regwrite_m (regwrite_m),
      .i_writereg_w (writereg_w),
      .i_regwrite_w (regwrite_w),
      .o_sel        (w_fwdb)
   );

   // Operand muxes; a bubble still forwards but carries regwrite 0
   always_comb begin
      srca_e      = r_idex.rd1;
      writedata_e = r_idex.rd2;
      case (w_fwda)
         FWD_MEM: srca_e = aluout_m;
         FWD_WB:  srca_e = result_w;
         FWD_REG: srca_e = r_idex.rd1;
         default: srca_e = r_idex.rd1;
      endcase
      case (w_fwdb)
         FWD_MEM: writedata_e = aluout_m;
         FWD_WB:  writedata_e = result_w;
         FWD_REG: writedata_e = r_idex.rd2;
         default: writedata_e = r_idex.rd2;
      endcase
      if (r_idex.alusrc) begin
         srcb_e = r_idex.signimm;
      end else begin
         srcb_e = writedata_e;
      end
      if (r_idex.regdst) begin
         writereg_e = r_idex.rd;
      end else begin
         writereg_e = r_idex.rt;
      end
   end

   assign alucont_e  = r_idex.alucontrol;
   assign regwrite_e = r_idex.regwrite;
   assign memwrite_e = r_idex.memwrite;
   assign memtoreg_e = r_idex.memtoreg;
   assign valid_e    = r_idex.valid;
   assign forwarda_e = w_fwda;
   assign forwardb_e = w_fwdb;

   // Load in EX whose target is read by the instruction now in decode
   assign lwstall = r_idex.memtoreg && r_idex.valid && (r_idex.rt != {RW{1'b0}}) &&
                    ((r_idex.rt == rs_d) || (r_idex.rt == rt_d));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expectations are queued as stimulus is
// driven and compared against the EX outputs once they are due.
module tb_id_ex_stage;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, stall_e, flush_e, valid_d;
   logic [31:0] rd1_d, rd2_d, signimm_d, aluout_m, result_w;
   logic [4:0]  rs_d, rt_d, rd_d, writereg_m, writereg_w;
   logic [2:0]  alucontrol_d;
   logic        alusrc_d, regdst_d, regwrite_d, memwrite_d, memtoreg_d;
   logic        regwrite_m, regwrite_w;
   logic [31:0] srca_e, srcb_e, writedata_e;
   logic [2:0]  alucont_e;
   logic [4:0]  writereg_e;
   logic        regwrite_e, memwrite_e, memtoreg_e, valid_e, lwstall;
   logic [1:0]  forwarda_e, forwardb_e;

   typedef struct packed {
      logic [31:0] srca;
      logic [31:0] srcb;
      logic [31:0] wdata;
      logic [2:0]  alucont;
      logic [4:0]  wreg;
      logic        rw;
      logic        mw;
      logic        mtr;
      logic        v;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        lws;
   } obs_t;

   obs_t exp_q[$];
   int   passes = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
      .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
      .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d),
      .aluout_m(aluout_m), .writereg_m(writereg_m), .regwrite_m(regwrite_m),
      .result_w(result_w), .writereg_w(writereg_w), .regwrite_w(regwrite_w),
      .srca_e(srca_e), .srcb_e(srcb_e), .alucont_e(alucont_e),
      .writedata_e(writedata_e), .writereg_e(writereg_e),
      .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e),
      .valid_e(valid_e), .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
      .lwstall(lwstall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] wd,
                       input logic [2:0] ac, input logic [4:0] wr, input logic rw,
                       input logic mw, input logic mtr, input logic v,
                       input logic [1:0] fa, input logic [1:0] fb, input logic lws);
      obs_t e;
      e = '{srca: sa, srcb: sb, wdata: wd, alucont: ac, wreg: wr, rw: rw, mw: mw,
            mtr: mtr, v: v, fa: fa, fb: fb, lws: lws};
      exp_q.push_back(e);
   endtask

   task automatic push_zero();
      push(32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic check(input string tag);
      obs_t obs;
      obs_t exp;
      obs = '{srca: srca_e, srcb: srcb_e, wdata: writedata_e, alucont: alucont_e,
              wreg: writereg_e, rw: regwrite_e, mw: memwrite_e, mtr: memtoreg_e,
              v: valid_e, fa: forwarda_e, fb: forwardb_e, lws: lwstall};
      total++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) begin
            passes++;
         end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   task automatic set_dec(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [2:0] ac, input logic asrc,
                          input logic rdst, input logic rw, input logic mw, input logic mtr);
      valid_d = v; rd1_d = r1; rd2_d = r2; signimm_d = imm;
      rs_d = rs; rt_d = rt; rd_d = rd; alucontrol_d = ac;
      alusrc_d = asrc; regdst_d = rdst; regwrite_d = rw; memwrite_d = mw; memtoreg_d = mtr;
   endtask

   task automatic set_mw(input logic rwm, input logic [4:0] wrm, input logic [31:0] am,
                         input logic rww, input logic [4:0] wrw, input logic [31:0] rsw);
      regwrite_m = rwm; writereg_m = wrm; aluout_m = am;
      regwrite_w = rww; writereg_w = wrw; result_w = rsw;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      set_dec(1'b1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_mw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // asynchronous reset before any clock edge
      #3 reset_n = 1'b0;
      #1 push_zero(); check("reset_async");
      tick(); tick();
      reset_n = 1'b1;

      // basic capture
      set_dec(1'b1, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd9, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      push(32'd5, 32'd7, 32'd7, ALU_ADD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick(); check("basic_capture");

      // both operands forwarded from MEM (MEM beats WB)
      set_dec(1'b1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd3, 5'd0, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_mw(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      push(32'hAA, 32'hAA, 32'hAA, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0);
      tick(); check("fwd_mem_both");

      regwrite_m = 1'b0;
      push(32'hBB, 32'hBB, 32'hBB, ALU_SUB, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0);
      #1 check("fwd_wb_both");

      // register 0 never forwards
      set_dec(1'b1, 32'h11, 32'h22, 32'h0, 5'd0, 5'd0, 5'd0, ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_mw(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      push(32'h11, 32'h22, 32'h22, ALU_SUB, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick(); check("fwd_r0_blocked");

      // immediate operand while rt is forwarded into store data
      set_dec(1'b1, 32'h33, 32'h44, 32'hFFFF_FFFC, 5'd1, 5'd6, 5'd7, ALU_OR, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      set_mw(1'b1, 5'd6, 32'h10, 1'b0, 5'd6, 32'h99);
      push(32'h33, 32'hFFFF_FFFC, 32'h10, ALU_OR, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
      tick(); check("imm_srcb");

      // load-use hazard on rs_d, then on rt_d
      set_mw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_dec(1'b1, 32'h100, 32'h55, 32'd8, 5'd5, 5'd4, 5'd0, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      rs_d = 5'd4; rt_d = 5'd9;
      push(32'h100, 32'd8, 32'h55, ALU_ADD, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
      #1 check("lwstall_rs");
      rs_d = 5'd9; rt_d = 5'd4;
      push(32'h100, 32'd8, 32'h55, ALU_ADD, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1);
      #1 check("lwstall_rt");

      // load targeting r0 never stalls
      set_dec(1'b1, 32'h100, 32'h55, 32'd8, 5'd5, 5'd0, 5'd0, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      rs_d = 5'd0; rt_d = 5'd0;
      push(32'h100, 32'd8, 32'h55, ALU_ADD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
      #1 check("lwstall_r0");

      // stall holds contents across three edges
      set_dec(1'b1, 32'hA1, 32'hA2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_AND, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      push(32'hA1, 32'hA2, 32'hA2, ALU_AND, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick(); check("pre_stall");
      stall_e = 1'b1;
      set_dec(1'b0, 32'hDEAD, 32'hBEEF, 32'h1234, 5'd11, 5'd12, 5'd13, ALU_SLT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         push(32'hA1, 32'hA2, 32'hA2, ALU_AND, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
         tick(); check($sformatf("stall_hold_%0d", i));
      end

      // flush beats stall
      flush_e = 1'b1;
      push_zero();
      tick(); check("flush_over_stall");
      flush_e = 1'b0; stall_e = 1'b0;

      // reserved alucontrol passes through, then reset mid-cycle
      set_dec(1'b1, 32'h5A, 32'h6B, 32'h0, 5'd7, 5'd8, 5'd10, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      push(32'h5A, 32'h6B, 32'h6B, 3'b011, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick(); check("alu_011_pass");
      #2 reset_n = 1'b0;
      push_zero();
      #1 check("reset_midcycle");
      push_zero();
      tick(); check("reset_held");
      reset_n = 1'b1; stall_e = 1'b1;
      push_zero();
      tick(); check("stall_after_reset");
      stall_e = 1'b0;
      push(32'h5A, 32'h6B, 32'h6B, 3'b011, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      tick(); check("capture_after_reset");

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
